// File: rtl/sdrc_init_seq.sv
// SDRAM power-up initialization sequencer: NOP wait, PRECHARGE-ALL, AUTO-REFRESH
// burst and MODE REGISTER SET, then hands the command bus to the core controller.
`timescale 1ns/1ps

module sdrc_init_seq #(
    parameter int PWR_WAIT = 500,
    parameter int AREF_CNT = 2
) (
    input  logic        sdram_clk,
    input  logic        sdram_resetn,
    input  logic        cfg_sdr_en,
    input  logic [12:0] cfg_sdr_mode_reg,
    input  logic [3:0]  cfg_sdr_trp_d,
    input  logic [3:0]  cfg_sdr_trfc_d,
    input  logic [3:0]  cfg_sdr_tmrd_d,
    output logic        sdr_cke,
    output logic        sdr_cs_n,
    output logic        sdr_ras_n,
    output logic        sdr_cas_n,
    output logic        sdr_we_n,
    output logic [12:0] sdr_addr,
    output logic [1:0]  sdr_ba,
    output logic        sdr_init_done,
    output logic        sdr_init_err
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_PRE,
        ST_WAIT_TRP,
        ST_AREF,
        ST_WAIT_TRFC,
        ST_MRS,
        ST_WAIT_TMRD,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [15:0] PWR_LOAD = (PWR_WAIT > 0) ? 16'(PWR_WAIT - 1) : 16'd0;
    localparam logic [3:0]  AREF_N   = 4'(AREF_CNT);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  aref_done;
    logic [3:0]  trp_q;
    logic [3:0]  trfc_q;
    logic [3:0]  tmrd_q;
    logic [12:0] mode_q;
    logic        cas_legal;

    // Wait counters count down to zero; a programmed delay of 0 behaves like 1.
    function automatic logic [15:0] delay_load(input logic [3:0] d);
        return (d == 4'd0) ? 16'd0 : {12'd0, d - 4'd1};
    endfunction

    assign cas_legal = (mode_q[6:4] == 3'd2) || (mode_q[6:4] == 3'd3);

    // Every output is registered together with the state that produces it, so the
    // command seen on the bus always belongs to the state just entered.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state         <= ST_IDLE;
            cnt           <= 16'd0;
            aref_done     <= 4'd0;
            trp_q         <= 4'd0;
            trfc_q        <= 4'd0;
            tmrd_q        <= 4'd0;
            mode_q        <= 13'd0;
            sdr_cke       <= 1'b0;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
            sdr_addr      <= 13'd0;
            sdr_ba        <= 2'd0;
            sdr_init_done <= 1'b0;
            sdr_init_err  <= 1'b0;
        end else begin
            sdr_cke  <= 1'b1;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
            sdr_addr <= 13'd0;
            sdr_ba   <= 2'd0;

            case (state)
                ST_IDLE: begin
                    sdr_cke <= cfg_sdr_en;
                    if (cfg_sdr_en) begin
                        trp_q  <= cfg_sdr_trp_d;
                        trfc_q <= cfg_sdr_trfc_d;
                        tmrd_q <= cfg_sdr_tmrd_d;
                        mode_q <= cfg_sdr_mode_reg;
                        cnt    <= PWR_LOAD;
                        state  <= ST_PWR_WAIT;
                    end
                end
                ST_PWR_WAIT: begin
                    if (cnt == 16'd0) begin
                        state    <= ST_PRE;
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_PRE;
                        sdr_addr <= 13'h0400;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_PRE: begin
                    cnt   <= delay_load(trp_q);
                    state <= ST_WAIT_TRP;
                end
                ST_WAIT_TRP: begin
                    if (cnt == 16'd0) begin
                        state <= ST_AREF;
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_AREF;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_AREF: begin
                    aref_done <= aref_done + 4'd1;
                    cnt       <= delay_load(trfc_q);
                    state     <= ST_WAIT_TRFC;
                end
                // After the last refresh the CAS latency decides between MRS and ERR.
                ST_WAIT_TRFC: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (aref_done < AREF_N) begin
                        state <= ST_AREF;
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_AREF;
                    end else if (cas_legal) begin
                        state    <= ST_MRS;
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_MRS;
                        sdr_addr <= mode_q;
                    end else begin
                        state        <= ST_ERR;
                        sdr_init_err <= 1'b1;
                    end
                end
                ST_MRS: begin
                    cnt   <= delay_load(tmrd_q);
                    state <= ST_WAIT_TMRD;
                end
                ST_WAIT_TMRD: begin
                    if (cnt == 16'd0) begin
                        state         <= ST_DONE;
                        sdr_init_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_DONE: ;
                ST_ERR: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
